// File: rtl/fp_mantis_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_mantis_addsub_pipe
// Brief    : 3-stage signed-magnitude mantissa add/sub with right (carry) and
//            left (cancellation) normalisation, valid/ready on both sides.
//            Optional macro FPADD_STICKY_EN keeps the bit lost on right shift.
// Revision : 1.0
// ============================================================================
module fp_mantis_addsub_pipe #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sub,
    input  logic [EXP_W-1:0]  exp,
    input  logic              sign_A,
    input  logic [MANT_W-1:0] mantis_A,
    input  logic              sign_B,
    input  logic [MANT_W-1:0] mantis_B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sign_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic [MANT_W-1:0] mantis_out,
    output logic              ovf,
    output logic              zero
);

    localparam int c_LZC_W = $clog2(MANT_W + 1);
    localparam int c_SH_W  = (EXP_W > c_LZC_W) ? EXP_W : c_LZC_W;
    localparam logic [EXP_W-1:0] c_EXP_MAX = '1;

    // Stage registers
    logic              r_s1_valid, r_s1_sign, r_s1_zero;
    logic [EXP_W-1:0]  r_s1_exp;
    logic [MANT_W:0]   r_s1_raw;

    logic              r_s2_valid, r_s2_sign, r_s2_zero, r_s2_ovf;
    logic [EXP_W-1:0]  r_s2_exp;
    logic [MANT_W-1:0] r_s2_mant;

    logic              r_s3_valid, r_s3_sign, r_s3_zero, r_s3_ovf;
    logic [EXP_W-1:0]  r_s3_exp;
    logic [MANT_W-1:0] r_s3_mant;

    logic w_s1_adv, w_s2_adv, w_s3_adv;

    assign w_s3_adv = !r_s3_valid || out_ready;
    assign w_s2_adv = !r_s2_valid || w_s3_adv;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    assign out_valid  = r_s3_valid;
    assign sign_out   = r_s3_sign;
    assign exp_out    = r_s3_exp;
    assign mantis_out = r_s3_mant;
    assign ovf        = r_s3_ovf;
    assign zero       = r_s3_zero;

    // ---------------- S1: magnitude add / subtract ----------------
    logic            w_eff_sub, w_s1_sign, w_s1_zero;
    logic [MANT_W:0] w_s1_raw;

    always_comb begin
        w_eff_sub = sign_A ^ sign_B ^ sub;
        w_s1_sign = sign_A;
        w_s1_raw  = '0;
        if (!w_eff_sub) begin
            w_s1_raw = {1'b0, mantis_A} + {1'b0, mantis_B};
        end else if (mantis_A >= mantis_B) begin
            w_s1_raw = {1'b0, mantis_A} - {1'b0, mantis_B};
        end else begin
            w_s1_raw  = {1'b0, mantis_B} - {1'b0, mantis_A};
            w_s1_sign = sign_B ^ sub;
        end
        w_s1_zero = (w_s1_raw == '0);
        if (w_s1_zero) begin
            w_s1_sign = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_raw   <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign <= w_s1_sign;
                r_s1_zero <= w_s1_zero;
                r_s1_exp  <= exp;
                r_s1_raw  <= w_s1_raw;
            end
        end
    end

    // ---------------- S2: right normalise on carry-out ----------------
    logic [EXP_W:0]    w_exp_inc;
    logic [EXP_W-1:0]  w_s2_exp;
    logic [MANT_W-1:0] w_s2_mant;
    logic              w_s2_ovf;

    always_comb begin
        w_exp_inc = {1'b0, r_s1_exp} + {{EXP_W{1'b0}}, 1'b1};
        w_s2_exp  = r_s1_exp;
        w_s2_mant = r_s1_raw[MANT_W-1:0];
        w_s2_ovf  = 1'b0;
        if (r_s1_raw[MANT_W]) begin
            w_s2_mant = r_s1_raw[MANT_W:1];
`ifdef FPADD_STICKY_EN
            w_s2_mant[0] = r_s1_raw[1] | r_s1_raw[0];
`endif
            w_s2_exp = w_exp_inc[EXP_W-1:0];
            // Reaching the reserved all-ones exponent (or beyond) is infinity
            if (w_exp_inc >= {1'b0, c_EXP_MAX}) begin
                w_s2_ovf  = 1'b1;
                w_s2_exp  = c_EXP_MAX;
                w_s2_mant = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_zero  <= 1'b0;
            r_s2_ovf   <= 1'b0;
            r_s2_exp   <= '0;
            r_s2_mant  <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sign <= r_s1_sign;
                r_s2_zero <= r_s1_zero;
                r_s2_ovf  <= w_s2_ovf;
                r_s2_exp  <= w_s2_exp;
                r_s2_mant <= w_s2_mant;
            end
        end
    end

    // ---------------- S3: left normalise, clamped at exponent 0 ----------------
    logic [c_LZC_W-1:0] w_lzc;
    logic [c_SH_W-1:0]  w_lzc_x, w_exp_x, w_shift;
    logic [EXP_W-1:0]   w_s3_exp;
    logic [MANT_W-1:0]  w_s3_mant;

    always_comb begin
        w_lzc = c_LZC_W'(MANT_W);
        for (int i = 0; i < MANT_W; i++) begin
            if (r_s2_mant[i]) begin
                w_lzc = c_LZC_W'(MANT_W - 1 - i);
            end
        end
        w_lzc_x   = c_SH_W'(w_lzc);
        w_exp_x   = c_SH_W'(r_s2_exp);
        w_shift   = (w_lzc_x < w_exp_x) ? w_lzc_x : w_exp_x;
        w_s3_mant = r_s2_mant << w_shift;
        w_s3_exp  = r_s2_exp - w_shift[EXP_W-1:0];
        if (r_s2_ovf) begin
            w_s3_mant = r_s2_mant;
            w_s3_exp  = r_s2_exp;
        end else if (r_s2_zero) begin
            w_s3_mant = '0;
            w_s3_exp  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_valid <= 1'b0;
            r_s3_sign  <= 1'b0;
            r_s3_zero  <= 1'b0;
            r_s3_ovf   <= 1'b0;
            r_s3_exp   <= '0;
            r_s3_mant  <= '0;
        end else if (w_s3_adv) begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_s3_sign <= r_s2_sign;
                r_s3_zero <= r_s2_zero;
                r_s3_ovf  <= r_s2_ovf;
                r_s3_exp  <= w_s3_exp;
                r_s3_mant <= w_s3_mant;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_mantis_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mantis_addsub_pipe
// Brief    : Directed-vector bench with an arithmetic reference model and a
//            per-cycle output scoreboard for fp_mantis_addsub_pipe.
// Revision : 1.0
// ============================================================================
module tb_fp_mantis_addsub_pipe;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 28;
`ifdef FPADD_STICKY_EN
    localparam logic [MANT_W-1:0] c_STK_M = 28'h8000001;
`else
    localparam logic [MANT_W-1:0] c_STK_M = 28'h8000000;
`endif

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  e;
        logic [MANT_W-1:0] m;
        logic              ovf;
        logic              zero;
    } res_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              sub = 1'b0;
    logic [EXP_W-1:0]  exp_i = '0;
    logic              sign_A = 1'b0;
    logic [MANT_W-1:0] mantis_A = '0;
    logic              sign_B = 1'b0;
    logic [MANT_W-1:0] mantis_B = '0;
    logic              out_ready = 1'b1;
    logic              in_ready, out_valid, sign_out, ovf, zero;
    logic [EXP_W-1:0]  exp_out;
    logic [MANT_W-1:0] mantis_out;
    res_t              dut_res;

    int   n_vec = 0;
    int   n_err = 0;
    res_t q[$];

    assign dut_res = {sign_out, exp_out, mantis_out, ovf, zero};

    always #5 clk = ~clk;

    fp_mantis_addsub_pipe #(.EXP_W(EXP_W), .MANT_W(MANT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .sub(sub), .exp(exp_i),
        .sign_A(sign_A), .mantis_A(mantis_A),
        .sign_B(sign_B), .mantis_B(mantis_B),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign_out(sign_out), .exp_out(exp_out), .mantis_out(mantis_out),
        .ovf(ovf), .zero(zero)
    );

    // Reference: plain integer arithmetic, normalisation by repeated doubling
    function automatic res_t model(input logic s, input logic [EXP_W-1:0] e,
                                   input logic sa, input logic [MANT_W-1:0] ma,
                                   input logic sb, input logic [MANT_W-1:0] mb);
        res_t   r;
        longint a, b, raw, lost;
        int     ex;
        r  = '0;
        a  = longint'(ma);
        b  = longint'(mb);
        ex = int'(e);
        if ((sa ^ sb ^ s) == 1'b0) begin
            raw = a + b;  r.sign = sa;
        end else if (a >= b) begin
            raw = a - b;  r.sign = sa;
        end else begin
            raw = b - a;  r.sign = sb ^ s;
        end
        if (raw == 0) begin
            r.sign = 1'b0;
            r.zero = 1'b1;
            return r;
        end
        if (raw >= (longint'(1) << MANT_W)) begin
            lost = raw % 2;
            raw  = raw / 2;
`ifdef FPADD_STICKY_EN
            if (lost != 0) raw = raw | 1;
`endif
            ex = ex + 1;
            if (ex >= (1 << EXP_W) - 1) begin
                r.ovf = 1'b1;
                r.e   = '1;
                r.m   = '0;
                return r;
            end
        end
        while (raw < (longint'(1) << (MANT_W - 1)) && ex > 0) begin
            raw = raw * 2;
            ex  = ex - 1;
        end
        r.e = ex[EXP_W-1:0];
        r.m = raw[MANT_W-1:0];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Scoreboard: every cycle with out_valid, the head of the queue must be on the outputs
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL stream: got unexpected result %h, required no output", dut_res);
                end else begin
                    if (dut_res !== q[0]) begin
                        n_err++;
                        $display("FAIL stream: got s=%0d e=%0d m=%h ovf=%0d zero=%0d, required s=%0d e=%0d m=%h ovf=%0d zero=%0d",
                                 sign_out, exp_out, mantis_out, ovf, zero,
                                 q[0].sign, q[0].e, q[0].m, q[0].ovf, q[0].zero);
                    end
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready)
                q.push_back(model(sub, exp_i, sign_A, mantis_A, sign_B, mantis_B));
        end
    end

    // Called just after a rising edge; returns just after the edge that took the beat
    task automatic send(input logic s, input logic [EXP_W-1:0] e,
                        input logic sa, input logic [MANT_W-1:0] ma,
                        input logic sb, input logic [MANT_W-1:0] mb);
        int guard = 0;
        in_valid = 1'b1;  sub = s;  exp_i = e;
        sign_A = sa;  mantis_A = ma;  sign_B = sb;  mantis_B = mb;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("send_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input res_t req);
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        check({name, "_latency"}, lat, 3);
        check(name, dut_res, req);
        @(posedge clk);
        #1;
    endtask

    task automatic dir(input string name, input logic s, input logic [EXP_W-1:0] e,
                       input logic sa, input logic [MANT_W-1:0] ma,
                       input logic sb, input logic [MANT_W-1:0] mb,
                       input logic xs, input logic [EXP_W-1:0] xe,
                       input logic [MANT_W-1:0] xm, input logic xo, input logic xz);
        res_t r;
        r.sign = xs;  r.e = xe;  r.m = xm;  r.ovf = xo;  r.zero = xz;
        send(s, e, sa, ma, sb, mb);
        expect_out(name, r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {out_valid, dut_res}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        @(posedge clk); #1;

        //   name        sub exp   sA A            sB B             s  exp   mant         ovf zero
        dir("basic_add",  0, 8'd127, 0, 28'h8000000, 0, 28'h8000000, 0, 8'd128, 28'h8000000, 0, 0);
        dir("cancel",     1, 8'd127, 0, 28'h8000000, 0, 28'h4000000, 0, 8'd126, 28'h8000000, 0, 0);
        dir("exact_zero", 1, 8'd127, 1, 28'h5000000, 1, 28'h5000000, 0, 8'd0,   28'h0000000, 0, 1);
        dir("denormal",   1, 8'd1,   0, 28'h8000000, 0, 28'h7000000, 0, 8'd0,   28'h2000000, 0, 0);
        dir("overflow",   0, 8'd254, 0, 28'hFFFFFFF, 0, 28'hFFFFFFF, 0, 8'hFF,  28'h0000000, 1, 0);
        dir("near_ovf",   0, 8'd253, 0, 28'hFFFFFFF, 0, 28'hFFFFFFF, 0, 8'd254, 28'hFFFFFFF, 0, 0);
        dir("sticky",     0, 8'd127, 0, 28'h8000001, 0, 28'h8000000, 0, 8'd128, c_STK_M,     0, 0);
        dir("neg_add",    0, 8'd100, 1, 28'h8000000, 1, 28'h4000000, 1, 8'd100, 28'hC000000, 0, 0);
        dir("mixed_a_lt", 0, 8'd100, 0, 28'h4000000, 1, 28'h8000000, 1, 8'd99,  28'h8000000, 0, 0);
        dir("sub_a_lt_b", 1, 8'd50,  0, 28'h2000000, 0, 28'hA000000, 1, 8'd50,  28'h8000000, 0, 0);
        dir("neg_sub",    1, 8'd10,  1, 28'h6000000, 1, 28'h2000000, 1, 8'd9,   28'h8000000, 0, 0);
        dir("exp0_tiny",  0, 8'd0,   0, 28'h0000001, 0, 28'h0000000, 0, 8'd0,   28'h0000001, 0, 0);
        dir("exp3_tiny",  0, 8'd3,   0, 28'h0000001, 0, 28'h0000000, 0, 8'd0,   28'h0000008, 0, 0);

        // Backpressure: six back-to-back beats against a five-cycle stall
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(i[0], 8'(60 + i), 1'b0, 28'h8000000 | 28'(i * 32'h0111111),
                         i[1], 28'(32'h0F00000 >> i));
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready_low", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge clk);
        check("bp_drained", q.size(), 0);
        @(posedge clk); #1;

        // Reset while the pipeline is full
        for (int i = 0; i < 5; i++)
            send(1'b0, 8'd90, i[0], 28'h9000000, 1'b0, 28'(i << 20));
        check("rst_pre_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1 check("rst_async_clear", {out_valid, dut_res}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_post_idle", {in_ready, out_valid}, 2'b10);
        @(posedge clk); #1;
        dir("post_reset", 0, 8'd127, 0, 28'h8000000, 0, 28'h8000000, 0, 8'd128, 28'h8000000, 0, 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_mantis_addsub_pipe.md
Name:
fp_mantis_addsub_pipe

Overview:
- Parametrised, pipelined successor to the combinational single-precision mantissa adder.
- Takes two operands already aligned to a common exponent and performs a signed-magnitude add or subtract.
- Normalises the result in both directions: right shift on carry-out, left shift on cancellation.
- Sits between the alignment shifter and the rounding stage of the FP add datapath; valid/ready handshake on both sides.

Parameters:
- EXP_W, 8: exponent width; all-ones exponent is reserved for overflow/infinity.
- MANT_W, 28: extended mantissa width (hidden bit at MANT_W-1, plus guard/round/sticky LSBs).

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts beat this cycle
- sub  input  1  1 = A-B, 0 = A+B
- exp  input  EXP_W  common (aligned) exponent
- sign_A  input  1  sign of A
- mantis_A  input  MANT_W  magnitude of A
- sign_B  input  1  sign of B
- mantis_B  input  MANT_W  magnitude of B
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sign_out  output  1  result sign
- exp_out  output  EXP_W  normalised exponent
- mantis_out  output  MANT_W  normalised mantissa
- ovf  output  1  exponent overflow (result is infinity)
- zero  output  1  exact zero result

Behaviour:
- Reset: all stage valid bits and every output register clear to 0. in_ready is 1 one cycle after reset release. Reset mid-operation discards all in-flight beats.
- Pipeline: 3 register stages, latency 3 cycles, throughput 1 beat/cycle while out_ready=1.
- Stage k advances when it is empty or stage k+1 advances. in_ready = !s1_valid || s1 advances. Transfer occurs when valid&&ready.
- Stall: with out_ready=0 the outputs hold stable and no beat is lost or reordered.
- S1, magnitude op: eff_sub = sign_A^sign_B^sub.
  - Add: raw = A+B, width MANT_W+1; sign = sign_A.
  - Sub with A>=B: raw = A-B; sign = sign_A.
  - Sub with A<B: raw = B-A; sign = sign_B^sub.
  - raw==0: sign forced to 0, zero=1.
- S2, right normalise: if raw[MANT_W]=1, shift raw right by 1 and set exp+1.
  - If exp+1 == 2^EXP_W-1: ovf=1, exp_out all-ones, mantis_out 0.
- S3, left normalise: lzc = leading zeros of the MANT_W-bit value. shift = min(lzc, exp).
  - Mantissa left by shift, exp - shift.
  - lzc>exp yields a denormal with exp_out 0.
  - zero: exp_out 0, mantis_out 0. ovf beats bypass S3 unchanged.
- ovf and zero are never both 1.

Optional Feature:
- Macro: FPADD_STICKY_EN.
- Defined: the S2 right shift ORs the shifted-out bit into mantis LSB (sticky preserved).
- Undefined: shifted-out bit is dropped (truncation).

Test Plan:
- Basic add: exp=127, A=B=28'h8000000, add, out_ready=1 -> after 3 cycles: mantis_out 28'h8000000, exp_out 128, sign 0, ovf 0, zero 0.
- Cancellation: exp=127, A=28'h8000000, B=28'h4000000, sub -> mantis_out 28'h8000000, exp_out 126.
- Zero and denormal:
  - Equal operands, sub, sign_A=1 -> zero=1, sign_out 0, exp_out 0, mantis_out 0.
  - exp=1, A=28'h8000000, B=28'h7000000, sub -> mantis_out 28'h2000000, exp_out 0.
- Overflow: exp=254, A=B=28'hFFFFFFF, add -> ovf=1, exp_out 8'hFF, mantis_out 0.
- Backpressure: 6 back-to-back beats, out_ready=0 for 5 cycles -> in_ready drops after 3 beats held; all 6 results emerge in order, outputs stable while stalled. Assert rst_n low mid-stream -> out_valid 0 immediately.
- Sticky: A=28'h8000001, B=28'h8000000, add -> mantis_out 28'h8000001 with FPADD_STICKY_EN, 28'h8000000 without; exp_out = exp+1.
